ds_fifo_ctrl: RTL and testbench

Per-channel Direct Sound FIFO controller. It sits between the CPU/DMA write path and the Direct Sound mixer's direct_A/direct_B input.
- Buffers 32 bytes of signed 8-bit PCM.
- Pops one sample on each overflow of the selected timer and holds it as a 24-bit mixer sample.
- Sequences DMA refills when the FIFO drains to half.
- Two instances are used: channel A and channel B.

---
 rtl/ds_pkg.sv | 24 ++
 rtl/ds_byte_fifo.sv | 75 +++++++
 rtl/ds_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_ds_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared types and defaults for the Direct Sound FIFO controller.
package ds_pkg;

   localparam int DS_DEPTH_BYTES  = 32;
   localparam int DS_REFILL_LEVEL = 16;
   localparam int DS_BURST_WORDS  = 4;
   localparam int DS_OUT_SHIFT    = 8;

   typedef logic [23:0] ds_sample_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      BURST
   } ds_dma_state_t;

   // Sign-extend a PCM byte to mixer width, then scale it into mixer range.
   function automatic ds_sample_t ds_expand(input logic [7:0] b, input int shift);
      ds_sample_t ext;
      ext = {{16{b[7]}}, b};
      return ext << shift;
   endfunction

endpackage

// File: rtl/ds_byte_fifo.sv
// Byte FIFO with 32-bit word writes and single-byte reads; clear is synchronous and dominant.
module ds_byte_fifo
   import ds_pkg::*;
#(
   parameter int DEPTH_BYTES = DS_DEPTH_BYTES
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           push,
   input  logic [31:0]                    push_data,
   input  logic                           pop,
   output logic [7:0]                     pop_data,
   output logic [$clog2(DEPTH_BYTES):0]   count,
   output logic                           can_push,
   output logic                           not_empty
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH_BYTES];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [AW-1:0] lane_addr [4];
   logic          push_ok;
   logic          pop_ok;

   assign can_push  = (count_reg <= CW'(DEPTH_BYTES - 4));
   assign not_empty = (count_reg != '0);
   assign push_ok   = push & can_push & ~clear;
   assign pop_ok    = pop & not_empty & ~clear;
   assign pop_data  = mem[rd_ptr_reg];
   assign count     = count_reg;

   // Byte lane gi of the word lands at wr_ptr+gi; pointers wrap naturally.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_addr[gi] = wr_ptr_reg + AW'(gi);
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (push_ok) begin
         for (int i = 0; i < 4; i++) begin
            mem[lane_addr[i]] <= push_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      count_next = count_reg;
      if (push_ok) count_next = count_next + CW'(4);
      if (pop_ok)  count_next = count_next - CW'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(4);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/ds_fifo_ctrl.sv
// Direct Sound channel: timer-driven sample pop, held mixer sample, status pulses and DMA refill sequencing.
module ds_fifo_ctrl
   import ds_pkg::*;
#(
   parameter int DEPTH_BYTES  = DS_DEPTH_BYTES,
   parameter int REFILL_LEVEL = DS_REFILL_LEVEL,
   parameter int BURST_WORDS  = DS_BURST_WORDS,
   parameter int OUT_SHIFT    = DS_OUT_SHIFT
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           timer0_ovf,
   input  logic                           timer1_ovf,
   input  logic                           timer_num,
   input  logic                           fifo_reset,
   input  logic                           wr_en,
   input  logic [31:0]                    wr_data,
   input  logic                           dma_ack,
   output logic                           dma_req,
   output ds_sample_t                     sample_out,
   output logic                           sample_tick,
   output logic [$clog2(DEPTH_BYTES):0]   count,
   output logic                           overflow,
   output logic                           underflow
);

   localparam int CW = $clog2(DEPTH_BYTES) + 1;
   localparam int WW = $clog2(BURST_WORDS) + 1;

   logic          pop;
   logic [7:0]    pop_data;
   logic [CW-1:0] fifo_count;
   logic          can_push;
   logic          not_empty;

   ds_sample_t    sample_reg;
   logic          tick_reg;
   logic          ovf_reg;
   logic          unf_reg;

   ds_dma_state_t state_reg;
   ds_dma_state_t state_next;
   logic [WW-1:0] word_cnt_reg;
   logic [WW-1:0] word_cnt_next;
   logic          dma_req_reg;

   assign pop = timer_num ? timer1_ovf : timer0_ovf;

   ds_byte_fifo #(
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (fifo_reset),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .count     (fifo_count),
      .can_push  (can_push),
      .not_empty (not_empty)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sample_reg <= '0;
         tick_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         unf_reg    <= 1'b0;
      end else begin
         tick_reg <= pop & not_empty & ~fifo_reset;
         ovf_reg  <= wr_en & ~can_push & ~fifo_reset;
         unf_reg  <= pop & ~not_empty & ~fifo_reset;
         if (fifo_reset)
            sample_reg <= '0;
         else if (pop && not_empty)
            sample_reg <= ds_expand(pop_data, OUT_SHIFT);
      end
   end

   // Burst words are counted whether or not the FIFO accepted them.
   always_comb begin
      state_next    = state_reg;
      word_cnt_next = word_cnt_reg;
      if (fifo_reset) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (fifo_count <= CW'(REFILL_LEVEL)) state_next = REQ;
            end
            REQ: begin
               if (dma_ack) begin
                  state_next    = BURST;
                  word_cnt_next = '0;
               end
            end
            BURST: begin
               if (wr_en) begin
                  word_cnt_next = word_cnt_reg + WW'(1);
                  if (word_cnt_reg == WW'(BURST_WORDS - 1)) state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         word_cnt_reg <= '0;
         dma_req_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         word_cnt_reg <= word_cnt_next;
         dma_req_reg  <= (state_next == REQ);
      end
   end

   assign dma_req     = dma_req_reg;
   assign sample_out  = sample_reg;
   assign sample_tick = tick_reg;
   assign overflow    = ovf_reg;
   assign underflow   = unf_reg;
   assign count       = fifo_count;

endmodule

// File: tb/tb_ds_fifo_ctrl.sv
// Directed bench for ds_fifo_ctrl: expected samples are queued at stimulus time and checked on sample_tick.
module tb_ds_fifo_ctrl;

   logic        clock;
   logic        reset;
   logic        timer0_ovf;
   logic        timer1_ovf;
   logic        timer_num;
   logic        fifo_reset;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        dma_ack;
   logic        dma_req;
   logic [23:0] sample_out;
   logic        sample_tick;
   logic [5:0]  count;
   logic        overflow;
   logic        underflow;

   int          errors = 0;
   int          checks = 0;
   logic [23:0] exp_q[$];
   logic [23:0] mon_exp;
   logic [23:0] drain_tbl [7];

   ds_fifo_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .timer0_ovf  (timer0_ovf),
      .timer1_ovf  (timer1_ovf),
      .timer_num   (timer_num),
      .fifo_reset  (fifo_reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .dma_ack     (dma_ack),
      .dma_req     (dma_req),
      .sample_out  (sample_out),
      .sample_tick (sample_tick),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pop0(input logic [23:0] e);
      timer_num  = 1'b0;
      timer0_ovf = 1'b1;
      exp_q.push_back(e);
      tick();
      timer0_ovf = 1'b0;
   endtask

   // Scoreboard monitor: every sample_tick must match the oldest queued expectation.
   always @(negedge clock) begin
      if (reset && sample_tick) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tick: actual=0x%0h required=no tick", sample_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (sample_out !== mon_exp) begin
               errors++;
               $display("FAIL sample: actual=0x%06h required=0x%06h", sample_out, mon_exp);
            end else begin
               $display("ok   sample: 0x%06h", sample_out);
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      timer0_ovf = 1'b0;
      timer1_ovf = 1'b0;
      timer_num  = 1'b0;
      fifo_reset = 1'b0;
      wr_en      = 1'b0;
      wr_data    = '0;
      dma_ack    = 1'b0;
      drain_tbl[0] = 24'h000000;
      drain_tbl[1] = 24'h000100;
      drain_tbl[2] = 24'h007F00;
      drain_tbl[3] = 24'h000200;
      drain_tbl[4] = 24'h000300;
      drain_tbl[5] = 24'h000400;
      drain_tbl[6] = 24'h000500;

      #2 reset = 1'b0;
      #6;
      chk("rst_count", count, 0);
      chk("rst_sample", sample_out, 0);
      chk("rst_dma_req", dma_req, 0);
      chk("rst_tick", sample_tick, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);
      #4 reset = 1'b1;
      tick();
      chk("dma_req_after_reset", dma_req, 1);

      // Four words, then three timer0 pops.
      wr(32'h04030201);
      wr(32'h08070605);
      wr(32'h0C0B0A09);
      wr(32'h100F0E0D);
      chk("count_16", count, 16);
      pop0(24'h000100);
      chk("tick_latency", sample_tick, 1);
      chk("sample_first", sample_out, 24'h000100);
      pop0(24'h000200);
      pop0(24'h000300);
      chk("count_13", count, 13);
      pop0(24'h000400);
      chk("count_12", count, 12);
      chk("dma_req_in_req", dma_req, 1);

      // fifo_reset while requesting.
      fifo_reset = 1'b1;
      tick();
      fifo_reset = 1'b0;
      chk("clr_count", count, 0);
      chk("clr_sample", sample_out, 0);
      chk("clr_dma_req", dma_req, 0);
      tick();
      chk("dma_req_rearm", dma_req, 1);

      // Refill burst.
      wr(32'h44332211);
      wr(32'h88776655);
      wr(32'hCCBBAA99);
      wr(32'h00FFEEDD);
      chk("burst_pre_count", count, 16);
      chk("burst_pre_req", dma_req, 1);
      dma_ack = 1'b1;
      tick();
      dma_ack = 1'b0;
      chk("burst_req_low", dma_req, 0);
      for (int i = 0; i < 4; i++) wr(32'h01010101 * (i + 1));
      chk("burst_count_32", count, 32);
      tick();
      tick();
      chk("idle_full_no_req", dma_req, 0);

      // Overflow, alone and with a simultaneous pop.
      wr(32'hDEADBEEF);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_count", count, 32);
      wr_en      = 1'b1;
      wr_data    = 32'hCAFEF00D;
      timer0_ovf = 1'b1;
      exp_q.push_back(24'h001100);
      tick();
      wr_en      = 1'b0;
      timer0_ovf = 1'b0;
      chk("ovf_pop_pulse", overflow, 1);
      chk("ovf_pop_count", count, 31);
      tick();
      chk("ovf_is_pulse", overflow, 0);

      // Unselected timer must not pop.
      timer_num  = 1'b0;
      timer1_ovf = 1'b1;
      tick();
      timer1_ovf = 1'b0;
      chk("unsel_timer1", count, 31);
      timer_num  = 1'b1;
      timer0_ovf = 1'b1;
      tick();
      timer0_ovf = 1'b0;
      timer_num  = 1'b0;
      chk("unsel_timer0", count, 31);

      // Sign extension, write+pop in one cycle, drain, underflow.
      fifo_reset = 1'b1;
      tick();
      fifo_reset = 1'b0;
      wr(32'h7F010080);
      chk("sx_count", count, 4);
      wr_en      = 1'b1;
      wr_data    = 32'h05040302;
      timer0_ovf = 1'b1;
      exp_q.push_back(24'hFF8000);
      tick();
      wr_en      = 1'b0;
      timer0_ovf = 1'b0;
      chk("wr_pop_count", count, 7);
      chk("sx_sample", sample_out, 24'hFF8000);
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(drain_tbl[i]);
         timer_num = i[0];
         if (i[0]) timer1_ovf = 1'b1;
         else      timer0_ovf = 1'b1;
         tick();
         timer0_ovf = 1'b0;
         timer1_ovf = 1'b0;
      end
      timer_num = 1'b0;
      chk("drained", count, 0);
      timer0_ovf = 1'b1;
      tick();
      timer0_ovf = 1'b0;
      chk("unf_pulse", underflow, 1);
      chk("unf_sample_held", sample_out, 24'h000500);
      chk("unf_no_tick", sample_tick, 0);
      tick();
      chk("unf_is_pulse", underflow, 0);

      tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
